opb_ctrl_master: RTL and testbench
==================================

Name: opb_ctrl_master

Overview:
- Single-beat OPB master (initiator) that turns a simple valid/ready command into one OPB read or write.
- Issues the command as a transfer to control slaves such as the DRAM sniffer register block, and returns data and status on a response port.
- Sits between a local controller (bring-up sequencer, DMA setup) and the OPB arbiter/bus.
- Handles arbitration, slave ack, errAck, retry and timeout.

Parameters:
- C_OPB_AWIDTH, 32, OPB address width (only 32 supported)
- C_OPB_DWIDTH, 32, OPB data width (only 32 supported)
- C_TIMEOUT, 16, XFER cycles without ack before local timeout (>=2)
- C_MAX_RETRY, 3, OPB_retry responses tolerated before failing the command
- C_RETRY_GAP, 2, idle cycles between a retry and the next M_request (>=1)

Ports:
- OPB_Clk  in  1  clock; all logic on rising edge
- OPB_Rst_n  in  1  synchronous reset, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
- cmd_rnw  in  1  1=read, 0=write
- cmd_addr  in  [31:0]  byte address
- cmd_be  in  [3:0]  byte enables, bit0 = data[7:0]
- cmd_wdata  in  [31:0]  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready
- rsp_rdata  out  [31:0]  read data (0 for writes/errors)
- rsp_err  out  [1:0]  00 ok, 01 errAck, 10 timeout, 11 retry exhausted
- M_request  out  1  bus request to arbiter
- M_select  out  1  OPB select
- M_RNW  out  1  read/not-write
- M_ABus  out  [0:31]  address
- M_BE  out  [0:3]  byte enables
- M_DBus  out  [0:31]  write data
- M_seqAddr  out  1  tied 0
- M_busLock  out  1  tied 0
- OPB_MGrant  in  1  arbiter grant
- OPB_DBus  in  [0:31]  read data
- OPB_xferAck  in  1  slave transfer ack
- OPB_errAck  in  1  slave error ack
- OPB_retry  in  1  slave retry
- OPB_toutSup  in  1  slave timeout suppress
- OPB_timeout  in  1  arbiter bus timeout

Behaviour:
- Reset (OPB_Rst_n=0 at edge): state IDLE; every output 0 except cmd_ready=1 one cycle after reset release; retry and watchdog counters 0.
- Reset mid-operation drops the command silently and produces no response.
- Bit mapping: M_ABus[0:31]=cmd_addr[31:0], bit-reversed index (M_ABus[31]=cmd_addr[0]).
- Byte lanes: M_BE[3]=cmd_be[0] .. M_BE[0]=cmd_be[3]. M_DBus[24:31]=wdata[7:0] .. M_DBus[0:7]=wdata[31:24]. rsp_rdata uses the same mapping from OPB_DBus.
- Command register: cmd is captured on handshake and held stable until RESP completes.
- Outputs when idle: M_ABus, M_BE, M_DBus and M_RNW are 0 whenever M_select=0 (OR-bus). M_DBus is 0 for reads even while selected.
- IDLE:
  - cmd_ready=1.
  - On handshake, capture cmd, clear retry count, go to REQ.
- REQ:
  - M_request=1.
  - On OPB_MGrant=1 sampled, go to XFER next cycle; M_request drops that same transition.
  - There is no grant timeout.
- XFER:
  - M_select=1 with all address/control/data driven.
  - Watchdog cleared on entry, increments each cycle unless OPB_toutSup=1 (holds).
  - Sampled events, priority highest first:
    1. OPB_errAck -> rsp_err=01.
    2. OPB_timeout, or watchdog==C_TIMEOUT-1 -> rsp_err=10.
    3. OPB_retry -> if retry count==C_MAX_RETRY then rsp_err=11, else increment count and go to GAP.
    4. OPB_xferAck -> rsp_err=00; capture OPB_DBus if read.
  - Error outcomes go to RESP with rdata=0.
  - M_select deasserts the cycle after the terminating event.
  - Minimum OPB latency: grant seen at cycle N, select at N+1; ack at N+1 gives rsp_valid at N+2.
- GAP: all bus outputs 0; wait C_RETRY_GAP cycles, then go to REQ.
- RESP:
  - rsp_valid=1 with rsp_rdata/rsp_err stable.
  - On rsp_ready, go to IDLE next cycle.
  - cmd_ready=0 until then; no command overlap, one outstanding at most.
- Simultaneous events: xferAck together with errAck reports 01; xferAck together with retry is treated as retry.
- A response is always generated for every accepted command absent reset.

Test Plan:
- Write addr 0x0000_0000, be=0x3, wdata=0x0000_ABCD; grant after 3 cycles, xferAck 2 cycles after select.
  Required: M_BE=0b0011, M_DBus[16:31]=0xABCD, rsp_err=00.
- Read addr 0x4, slave returns OPB_DBus=0x0000_0001 with immediate xferAck.
  Required: rsp_rdata=0x1, rsp_valid exactly 2 cycles after grant sampled, M_DBus=0 throughout.
- Slave never acks, C_TIMEOUT=16.
  Required: select high exactly 16 cycles, rsp_err=10. Repeat with OPB_toutSup held 10 cycles: select high 26 cycles.
- Slave asserts OPB_retry on 3 attempts, then xferAck.
  Required: 4 select phases, ≥2 idle cycles between them, rsp_err=00. With 4 retries: rsp_err=11, no 5th select.
- errAck and xferAck in the same cycle.
  Required: rsp_err=01, rsp_rdata=0. Hold rsp_ready=0 for 5 cycles: rsp_valid and data stable, cmd_ready=0.
- Assert OPB_Rst_n=0 during XFER.
  Required: next edge all outputs 0, no rsp_valid. After release, a new command completes normally.

Source files
------------

// File: rtl/opb_ctrl_master.sv
// Single-beat OPB master: turns a valid/ready command into one OPB read or write
// and returns data plus status (ok, errAck, timeout, retry exhausted) on a response port.
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | ready for a command (cmd_ready=1)
// S_REQ  | M_request to arbiter, waiting for OPB_MGrant
// S_XFER | M_select driven, waiting for ack/errAck/retry/timeout
// S_GAP  | back-off after a retry before requesting again
// S_RESP | response held on rsp_* until rsp_ready
module opb_ctrl_master #(
  parameter int C_OPB_AWIDTH = 32,
  parameter int C_OPB_DWIDTH = 32,
  parameter int C_TIMEOUT    = 16,
  parameter int C_MAX_RETRY  = 3,
  parameter int C_RETRY_GAP  = 2
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_rnw,
  input  logic [C_OPB_AWIDTH-1:0]   cmd_addr,
  input  logic [3:0]                cmd_be,
  input  logic [C_OPB_DWIDTH-1:0]   cmd_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [C_OPB_DWIDTH-1:0]   rsp_rdata,
  output logic [1:0]                rsp_err,
  output logic                      M_request,
  output logic                      M_select,
  output logic                      M_RNW,
  output logic [0:C_OPB_AWIDTH-1]   M_ABus,
  output logic [0:3]                M_BE,
  output logic [0:C_OPB_DWIDTH-1]   M_DBus,
  output logic                      M_seqAddr,
  output logic                      M_busLock,
  input  logic                      OPB_MGrant,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_xferAck,
  input  logic                      OPB_errAck,
  input  logic                      OPB_retry,
  input  logic                      OPB_toutSup,
  input  logic                      OPB_timeout
);

  localparam int RT_W = (C_MAX_RETRY < 1) ? 1 : $clog2(C_MAX_RETRY + 1);
  localparam int WD_W = $clog2(C_TIMEOUT);
  localparam int GP_W = (C_RETRY_GAP < 2) ? 1 : $clog2(C_RETRY_GAP);

  localparam logic [RT_W-1:0] RT_MAX  = RT_W'(C_MAX_RETRY);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(C_TIMEOUT - 1);
  localparam logic [GP_W-1:0] GP_LAST = GP_W'(C_RETRY_GAP - 1);

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ACK   = 2'b01;
  localparam logic [1:0] ERR_TOUT  = 2'b10;
  localparam logic [1:0] ERR_RETRY = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_XFER,
    S_GAP,
    S_RESP
  } state_t;

  state_t                  state_q, state_d;
  logic                    rdy_en_q, rdy_en_d;
  logic                    rnw_q, rnw_d;
  logic [C_OPB_AWIDTH-1:0] addr_q, addr_d;
  logic [3:0]              be_q, be_d;
  logic [C_OPB_DWIDTH-1:0] wdata_q, wdata_d;
  logic [C_OPB_DWIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]              err_q, err_d;
  logic [RT_W-1:0]         retry_q, retry_d;
  logic [WD_W-1:0]         wdog_q, wdog_d;
  logic [GP_W-1:0]         gap_q, gap_d;

  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      state_q  <= S_IDLE;
      rdy_en_q <= 1'b0;
      rnw_q    <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= ERR_OK;
      retry_q  <= '0;
      wdog_q   <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= rdy_en_d;
      rnw_q    <= rnw_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      retry_q  <= retry_d;
      wdog_q   <= wdog_d;
      gap_q    <= gap_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rdy_en_d = 1'b1;
    rnw_d    = rnw_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    retry_d  = retry_q;
    wdog_d   = wdog_q;
    gap_d    = gap_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && rdy_en_q) begin
          rnw_d   = cmd_rnw;
          addr_d  = cmd_addr;
          be_d    = cmd_be;
          wdata_d = cmd_wdata;
          rdata_d = '0;
          err_d   = ERR_OK;
          retry_d = '0;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        if (OPB_MGrant) begin
          wdog_d  = '0;
          state_d = S_XFER;
        end
      end

      S_XFER: begin
        if (!OPB_toutSup) begin
          wdog_d = wdog_q + 1'b1;
        end
        // Priority: errAck > timeout > retry > xferAck
        if (OPB_errAck) begin
          err_d   = ERR_ACK;
          rdata_d = '0;
          state_d = S_RESP;
        end else if (OPB_timeout || (wdog_q == WD_LAST)) begin
          err_d   = ERR_TOUT;
          rdata_d = '0;
          state_d = S_RESP;
        end else if (OPB_retry) begin
          if (retry_q == RT_MAX) begin
            err_d   = ERR_RETRY;
            rdata_d = '0;
            state_d = S_RESP;
          end else begin
            retry_d = retry_q + 1'b1;
            gap_d   = '0;
            state_d = S_GAP;
          end
        end else if (OPB_xferAck) begin
          err_d   = ERR_OK;
          rdata_d = rnw_q ? OPB_DBus : '0;
          state_d = S_RESP;
        end
      end

      S_GAP: begin
        if (gap_q == GP_LAST) begin
          state_d = S_REQ;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs are zero while deselected so they can be OR-ed onto the OPB.
  always_comb begin
    cmd_ready = (state_q == S_IDLE) && rdy_en_q;
    M_request = (state_q == S_REQ);
    M_select  = (state_q == S_XFER);
    M_RNW     = M_select && rnw_q;
    M_ABus    = M_select ? addr_q : '0;
    M_BE      = M_select ? be_q : '0;
    M_DBus    = (M_select && !rnw_q) ? wdata_q : '0;
    M_seqAddr = 1'b0;
    M_busLock = 1'b0;
    rsp_valid = (state_q == S_RESP);
    rsp_rdata = rsp_valid ? rdata_q : '0;
    rsp_err   = rsp_valid ? err_q : ERR_OK;
  end

endmodule

// File: tb/tb_opb_ctrl_master.sv
// Directed bench for opb_ctrl_master: arbitration, ack, errAck, timeout, retry and reset.
module tb_opb_ctrl_master;

  logic        OPB_Clk = 1'b0;
  logic        OPB_Rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_rnw = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [3:0]  cmd_be = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        M_request, M_select, M_RNW, M_seqAddr, M_busLock;
  logic [0:31] M_ABus;
  logic [0:3]  M_BE;
  logic [0:31] M_DBus;
  logic        OPB_MGrant = 1'b0;
  logic [0:31] OPB_DBus = '0;
  logic        OPB_xferAck = 1'b0;
  logic        OPB_errAck = 1'b0;
  logic        OPB_retry = 1'b0;
  logic        OPB_toutSup = 1'b0;
  logic        OPB_timeout = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  opb_ctrl_master dut (
    .OPB_Clk(OPB_Clk), .OPB_Rst_n(OPB_Rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
    .cmd_addr(cmd_addr), .cmd_be(cmd_be), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .M_request(M_request), .M_select(M_select), .M_RNW(M_RNW), .M_ABus(M_ABus),
    .M_BE(M_BE), .M_DBus(M_DBus), .M_seqAddr(M_seqAddr), .M_busLock(M_busLock),
    .OPB_MGrant(OPB_MGrant), .OPB_DBus(OPB_DBus), .OPB_xferAck(OPB_xferAck),
    .OPB_errAck(OPB_errAck), .OPB_retry(OPB_retry), .OPB_toutSup(OPB_toutSup),
    .OPB_timeout(OPB_timeout)
  );

  always #5 OPB_Clk = ~OPB_Clk;

  initial begin
    #200000;
    $display("FAIL global_watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic nedge();
    @(negedge OPB_Clk);
  endtask

  // Present a command for one cycle; caller has confirmed cmd_ready.
  task automatic send_cmd(input logic rnw, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata);
    cmd_rnw = rnw; cmd_addr = addr; cmd_be = be; cmd_wdata = wdata;
    cmd_valid = 1'b1;
    nedge();
    cmd_valid = 1'b0;
  endtask

  task automatic consume_rsp();
    rsp_ready = 1'b1;
    nedge();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    OPB_Rst_n = 1'b0;
    repeat (3) nedge();
    n_checks++;
    if ({cmd_ready, rsp_valid, M_request, M_select, M_RNW, M_seqAddr, M_busLock} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {cmd_ready, rsp_valid, M_request, M_select, M_RNW, M_seqAddr, M_busLock});
    end
    n_checks++;
    if ({M_ABus, M_BE, M_DBus, rsp_rdata, rsp_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h %h %h want all 0", M_ABus, M_BE, M_DBus, rsp_rdata, rsp_err);
    end
    OPB_Rst_n = 1'b1;
    n_checks++;
    if (cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_early: got %b want 0", cmd_ready);
    end
    nedge();
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_after: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    send_cmd(1'b0, 32'h0000_0000, 4'h3, 32'h0000_ABCD);
    n_checks++;
    if ({M_request, M_select, cmd_ready} !== 3'b100) begin
      n_fail++;
      $display("FAIL wr_req: got req/sel/rdy %b want 100", {M_request, M_select, cmd_ready});
    end
    nedge();
    nedge();
    n_checks++;
    if ({M_request, M_select, M_DBus} !== {2'b10, 32'h0}) begin
      n_fail++;
      $display("FAIL wr_wait_grant: got req/sel %b dbus %h want 10 / 0", {M_request, M_select}, M_DBus);
    end
    OPB_MGrant = 1'b1;
    nedge();
    OPB_MGrant = 1'b0;
    n_checks++;
    if ({M_request, M_select, M_RNW} !== 3'b010) begin
      n_fail++;
      $display("FAIL wr_select: got req/sel/rnw %b want 010", {M_request, M_select, M_RNW});
    end
    n_checks++;
    if (M_BE !== 4'b0011 || M_DBus[16:31] !== 16'hABCD || M_DBus !== 32'h0000_ABCD || M_ABus !== 32'h0) begin
      n_fail++;
      $display("FAIL wr_bus: got be %b dbus %h abus %h want 0011 0000abcd 00000000", M_BE, M_DBus, M_ABus);
    end
    nedge();
    OPB_xferAck = 1'b1;
    nedge();
    OPB_xferAck = 1'b0;
    n_checks++;
    if ({rsp_valid, M_select, rsp_err} !== 4'b1000 || rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL wr_rsp: got vld/sel/err %b rdata %h want 1000 / 0", {rsp_valid, M_select, rsp_err}, rsp_rdata);
    end
    consume_rsp();
    n_checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL wr_done: got vld/rdy %b want 01", {rsp_valid, cmd_ready});
    end
  endtask

  task automatic test_read();
    send_cmd(1'b1, 32'h0000_0004, 4'hF, 32'hDEAD_BEEF);
    OPB_MGrant = 1'b1;
    nedge();
    OPB_MGrant = 1'b0;
    n_checks++;
    if ({M_select, M_RNW} !== 2'b11 || M_ABus !== 32'h4 || M_DBus !== 32'h0 || M_BE !== 4'hF) begin
      n_fail++;
      $display("FAIL rd_bus: got sel/rnw %b abus %h dbus %h be %b want 11 00000004 0 1111",
               {M_select, M_RNW}, M_ABus, M_DBus, M_BE);
    end
    OPB_DBus = 32'h0000_0001;
    OPB_xferAck = 1'b1;
    nedge();
    OPB_xferAck = 1'b0;
    OPB_DBus = '0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1 || rsp_err !== 2'b00 || M_DBus !== 32'h0) begin
      n_fail++;
      $display("FAIL rd_rsp: got vld %b rdata %h err %b dbus %h want 1 00000001 00 0",
               rsp_valid, rsp_rdata, rsp_err, M_DBus);
    end
    consume_rsp();
  endtask

  task automatic test_timeout(input bit sup, input int exp_cnt);
    int cnt;
    cnt = 0;
    send_cmd(1'b0, 32'h0000_0100, 4'hF, 32'h1234_5678);
    OPB_MGrant = 1'b1;
    nedge();
    OPB_MGrant = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!M_select) break;
      cnt++;
      OPB_toutSup = sup && (cnt <= 10);
      nedge();
    end
    OPB_toutSup = 1'b0;
    n_checks++;
    if (cnt != exp_cnt) begin
      n_fail++;
      $display("FAIL timeout_len(sup=%0d): got %0d select cycles want %0d", sup, cnt, exp_cnt);
    end
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 2'b10 || rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL timeout_rsp(sup=%0d): got vld %b err %b rdata %h want 1 10 0", sup, rsp_valid, rsp_err, rsp_rdata);
    end
    consume_rsp();
  endtask

  // Arbiter grants at once; slave acks every phase, also asserting retry on the
  // first n_retry phases (ack+retry must be treated as retry).
  task automatic test_retry(input int n_retry, input int exp_phases,
                            input logic [1:0] exp_err, input logic [31:0] exp_rdata);
    int phases, gap, min_gap;
    bit prev_sel, done;
    phases = 0; gap = 0; min_gap = 1000; prev_sel = 1'b0; done = 1'b0;
    send_cmd(1'b1, 32'h0000_0010, 4'hF, 32'h0);
    for (int i = 0; i < 300 && !done; i++) begin
      if (rsp_valid) begin
        done = 1'b1;
      end else begin
        if (M_select && !prev_sel) begin
          phases++;
          if (phases > 1 && gap < min_gap) min_gap = gap;
          gap = 0;
        end
        if (!M_select) gap++;
        prev_sel = M_select;
        OPB_MGrant = M_request;
        OPB_xferAck = M_select;
        OPB_retry = M_select && (phases <= n_retry);
        OPB_DBus = M_select ? 32'h1234_5678 : 32'h0;
        nedge();
      end
    end
    OPB_MGrant = 1'b0; OPB_xferAck = 1'b0; OPB_retry = 1'b0; OPB_DBus = '0;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL retry_done(n=%0d): got no response want rsp_valid", n_retry);
    end
    n_checks++;
    if (phases != exp_phases) begin
      n_fail++;
      $display("FAIL retry_phases(n=%0d): got %0d want %0d", n_retry, phases, exp_phases);
    end
    n_checks++;
    if (min_gap < 2) begin
      n_fail++;
      $display("FAIL retry_gap(n=%0d): got %0d idle cycles want >=2", n_retry, min_gap);
    end
    n_checks++;
    if (rsp_err !== exp_err || rsp_rdata !== exp_rdata) begin
      n_fail++;
      $display("FAIL retry_rsp(n=%0d): got err %b rdata %h want %b %h", n_retry, rsp_err, rsp_rdata, exp_err, exp_rdata);
    end
    consume_rsp();
  endtask

  task automatic test_err_ack();
    send_cmd(1'b1, 32'h0000_0020, 4'hF, 32'h0);
    OPB_MGrant = 1'b1;
    nedge();
    OPB_MGrant = 1'b0;
    OPB_errAck = 1'b1;
    OPB_xferAck = 1'b1;
    OPB_DBus = 32'hFFFF_FFFF;
    nedge();
    OPB_errAck = 1'b0;
    OPB_xferAck = 1'b0;
    OPB_DBus = '0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({rsp_valid, cmd_ready, M_select} !== 3'b100 || rsp_err !== 2'b01 || rsp_rdata !== 32'h0) begin
        n_fail++;
        $display("FAIL errack_hold[%0d]: got vld/rdy/sel %b err %b rdata %h want 100 01 0",
                 i, {rsp_valid, cmd_ready, M_select}, rsp_err, rsp_rdata);
      end
      nedge();
    end
    consume_rsp();
    n_checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL errack_done: got vld/rdy %b want 01", {rsp_valid, cmd_ready});
    end
  endtask

  task automatic test_reset_mid();
    send_cmd(1'b0, 32'h0000_0040, 4'hF, 32'h5555_AAAA);
    OPB_MGrant = 1'b1;
    nedge();
    OPB_MGrant = 1'b0;
    n_checks++;
    if (M_select !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_sel: got %b want 1", M_select);
    end
    OPB_Rst_n = 1'b0;
    nedge();
    n_checks++;
    if ({cmd_ready, rsp_valid, M_request, M_select, M_RNW} !== 5'b0 ||
        {M_ABus, M_BE, M_DBus, rsp_rdata, rsp_err} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outs: got ctrl %b abus %h be %b dbus %h want all 0",
               {cmd_ready, rsp_valid, M_request, M_select, M_RNW}, M_ABus, M_BE, M_DBus);
    end
    OPB_Rst_n = 1'b1;
    nedge();
    n_checks++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL rstmid_release: got rdy/vld %b want 10", {cmd_ready, rsp_valid});
    end
    send_cmd(1'b1, 32'h8000_0001, 4'b0001, 32'h0);
    OPB_MGrant = 1'b1;
    nedge();
    OPB_MGrant = 1'b0;
    n_checks++;
    if (M_ABus !== 32'h8000_0001 || M_BE !== 4'b0001 || M_ABus[0] !== 1'b1 || M_BE[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_bus: got abus %h be %b want 80000001 0001", M_ABus, M_BE);
    end
    OPB_DBus = 32'hCAFE_0001;
    OPB_xferAck = 1'b1;
    nedge();
    OPB_xferAck = 1'b0;
    OPB_DBus = '0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 2'b00 || rsp_rdata !== 32'hCAFE_0001) begin
      n_fail++;
      $display("FAIL rstmid_rsp: got vld %b err %b rdata %h want 1 00 cafe0001", rsp_valid, rsp_err, rsp_rdata);
    end
    consume_rsp();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout(1'b0, 16);
    test_timeout(1'b1, 26);
    test_retry(3, 4, 2'b00, 32'h1234_5678);
    test_retry(4, 4, 2'b11, 32'h0);
    test_err_ack();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
